lsb_mem_sequencer: RTL and testbench
====================================

LSB_MEM_SEQUENCER -- requirements
Module: lsb_mem_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: ports clk_in and rst_in.
REQ-002 SHALL have these ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- req_valid  in  1  load/store request present
- req_ready  out  1  sequencer can accept a request
- req_wr  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=word
- req_signed  in  1  sign-extend load result
- req_addr  in  32  byte address of first byte
- req_wdata  in  32  store data, little-endian
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- lsb_addr  out  32  byte address to the memory controller
- lsb_data  out  8  store byte to the memory controller
- lsb_wr  out  1  write strobe
- lsb_en  out  1  memory access request this cycle
- lsb_read_data  in  8  read byte, one cycle after its lsb_en
- lsb_valid  in  1  registered copy of lsb_en from the memory controller
- flush  in  1  abort speculative work
REQ-003 SHALL have no parameters; the size encodings come from const_def.v.

Function
REQ-004 SHALL use the states IDLE, ISSUE, DRAIN and DONE.
REQ-005 SHALL drive req_ready=1 only in IDLE, and SHALL accept a request when req_valid&&req_ready.
REQ-006 SHALL latch addr, wdata, size, signed and wr on accept, and SHALL set the byte count N to 1, 2 or 4 from size (11 gives 4).
REQ-007 In ISSUE, SHALL drive lsb_en=1 for exactly N consecutive cycles at issue index k=0..N-1:
- lsb_addr = latched addr + k (mod 2^32)
- lsb_wr = latched wr
- lsb_data = wdata[8k+7:8k]
REQ-008 Outside ISSUE, lsb_en, lsb_wr, lsb_addr and lsb_data SHALL be 0.
REQ-009 For a load, SHALL write lsb_read_data into byte lane j of the assembly register on the j-th cycle in which lsb_valid=1 after accept; it SHALL ignore lsb_valid at all other times.
REQ-010 For a load: ISSUE→DRAIN after the last issue; DRAIN→DONE once N bytes are captured; DONE→IDLE.
REQ-011 For a store: ISSUE→DONE after the last issue; DONE→IDLE.
REQ-012 resp_valid SHALL be 1 only in DONE, for exactly one cycle per accepted request.
REQ-013 Latency from the accept cycle 0:
- load: lsb_en in cycles 1..N; resp_valid in cycle N+2
- store: lsb_en in cycles 1..N; resp_valid in cycle N+1
REQ-014 Load result:
- byte, signed: sign-extended from bit 7
- byte, unsigned: zero-extended
- half, signed: sign-extended from bit 15
- half, unsigned: zero-extended
- word: unchanged
REQ-015 resp_rdata SHALL hold its value until the next DONE; for stores it SHALL be 0.
REQ-016 Misaligned addresses SHALL be legal and handled byte-serially without an exception.
REQ-017 flush=1 during a load (ISSUE, DRAIN or DONE) SHALL force IDLE next cycle, with no resp_valid and lsb_en=0 from that cycle on.
REQ-018 flush SHALL be ignored during a store; the store SHALL complete all N writes and pulse resp_valid.
REQ-019 flush in IDLE SHALL block accept in that cycle.
REQ-020 A new request SHALL be accepted no earlier than the cycle after DONE, so back-to-back requests have a 1-cycle gap.

Reset
REQ-021 rst_in=1 SHALL set, at the next edge:
- state IDLE
- req_ready=1, resp_valid=0, resp_rdata=0
- lsb_en=0, lsb_wr=0, lsb_addr=0, lsb_data=0
- counters and assembly register 0
REQ-022 Reset mid-store SHALL stop writes immediately; a partial store is accepted behaviour.

Structure
REQ-023 const_def.v SHALL hold the `MEM_SIZE_B/H/W encodings and the state encodings.
REQ-024 Load extension SHALL be a sub-module load_extender (combinational: 32-bit data, size, signed → 32-bit result).
REQ-025 The issue counter and the capture counter SHALL be separate 3-bit registers.

Verification
REQ-026 LW at 0x100, memory bytes 0x78,0x56,0x34,0x12 → lsb_addr 0x100..0x103 in cycles 1..4; resp_valid in cycle 6 with 0x12345678.
REQ-027 LB signed at 0x200 holding 0x80 → resp_rdata 0xFFFFFF80; LBU at the same address → 0x00000080.
REQ-028 SH at 0x301 with wdata 0xABCDBEEF → writes 0xEF@0x301, 0xBE@0x302, lsb_wr=1; resp_valid in cycle 3; memory byte 0x303 unchanged.
REQ-029 LW at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 issued (wrap-around).
REQ-030 Flush and reset interactions:
- flush in cycle 2 of an LW → lsb_en=0 from cycle 3, no resp_valid, req_ready=1 in cycle 3.
- flush during an SW → all 4 writes and resp_valid still occur.
- rst_in mid-LW → all outputs reach their reset values next cycle.

Source files
------------

// File: rtl/lsb_mem_sequencer_pkg.sv
// Shared encodings for the byte-serial load/store sequencer: access sizes, FSM states
// and the size-to-byte-count mapping.
package lsb_mem_sequencer_pkg;

  localparam logic [1:0] MemSizeB = 2'b00;
  localparam logic [1:0] MemSizeH = 2'b01;
  localparam logic [1:0] MemSizeW = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Encoding 11 is treated as a word access.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      MemSizeB: return 3'd1;
      MemSizeH: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsb_mem_sequencer_load_extender.sv
// Sign/zero extension of an assembled little-endian load value to 32 bits.
module load_extender
  import lsb_mem_sequencer_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (size_i)
      MemSizeB: result_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
      MemSizeH: result_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default:  result_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsb_mem_sequencer.sv
// Breaks byte/half/word loads and stores into byte-serial memory accesses and
// reassembles load data, with flush abort for loads.
module lsb_mem_sequencer
  import lsb_mem_sequencer_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] lsb_addr,
  output logic [7:0]  lsb_data,
  output logic        lsb_wr,
  output logic        lsb_en,
  input  logic [7:0]  lsb_read_data,
  input  logic        lsb_valid,
  input  logic        flush
);

  state_e      state_q;
  logic [2:0]  issue_cnt_q, cap_cnt_q, n_q;
  logic [31:0] addr_q, wdata_q, asm_q, resp_rdata_q, lsb_addr_q;
  logic [1:0]  size_q;
  logic        signed_q, wr_q, resp_q, lsb_en_q, lsb_wr_q;
  logic [7:0]  lsb_data_q;

  logic        accept, capture, load_flush;
  logic [31:0] asm_next, ext_result;

  assign req_ready  = (state_q == StIdle) && !flush;
  assign accept     = req_valid && req_ready;
  assign load_flush = flush && !wr_q && (state_q != StIdle);
  assign capture    = !wr_q && lsb_valid && (cap_cnt_q < n_q) &&
                      ((state_q == StIssue) || (state_q == StDrain));

  always_comb begin
    asm_next = asm_q;
    if (capture) asm_next[{cap_cnt_q[1:0], 3'b000} +: 8] = lsb_read_data;
  end

  load_extender u_load_extender (
    .data_i   (asm_next),
    .size_i   (size_q),
    .signed_i (signed_q),
    .result_o (ext_result)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      issue_cnt_q  <= 3'd0;
      cap_cnt_q    <= 3'd0;
      n_q          <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      asm_q        <= 32'd0;
      resp_rdata_q <= 32'd0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      wr_q         <= 1'b0;
      resp_q       <= 1'b0;
      lsb_en_q     <= 1'b0;
      lsb_wr_q     <= 1'b0;
      lsb_addr_q   <= 32'd0;
      lsb_data_q   <= 8'd0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            size_q      <= req_size;
            signed_q    <= req_signed;
            wr_q        <= req_wr;
            n_q         <= size_to_bytes(req_size);
            issue_cnt_q <= 3'd1;
            cap_cnt_q   <= 3'd0;
            asm_q       <= 32'd0;
            lsb_en_q    <= 1'b1;
            lsb_wr_q    <= req_wr;
            lsb_addr_q  <= req_addr;
            lsb_data_q  <= req_wdata[7:0];
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (capture) begin
            asm_q     <= asm_next;
            cap_cnt_q <= cap_cnt_q + 3'd1;
          end
          if (load_flush || (issue_cnt_q == n_q)) begin
            lsb_en_q   <= 1'b0;
            lsb_wr_q   <= 1'b0;
            lsb_addr_q <= 32'd0;
            lsb_data_q <= 8'd0;
            if (load_flush) begin
              state_q <= StIdle;
            end else if (wr_q) begin
              state_q      <= StDone;
              resp_q       <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q <= StDrain;
            end
          end else begin
            lsb_addr_q  <= addr_q + {29'd0, issue_cnt_q};
            lsb_data_q  <= wdata_q[{issue_cnt_q[1:0], 3'b000} +: 8];
            issue_cnt_q <= issue_cnt_q + 3'd1;
          end
        end
        StDrain: begin
          if (load_flush) begin
            state_q <= StIdle;
          end else if (capture) begin
            asm_q     <= asm_next;
            cap_cnt_q <= cap_cnt_q + 3'd1;
            if ((cap_cnt_q + 3'd1) == n_q) begin
              state_q      <= StDone;
              resp_q       <= 1'b1;
              resp_rdata_q <= ext_result;
            end
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

  // A load flushed while already in DONE must not present its completion.
  assign resp_valid = resp_q && !(flush && !wr_q);
  assign resp_rdata = resp_rdata_q;
  assign lsb_en     = lsb_en_q;
  assign lsb_wr     = lsb_wr_q;
  assign lsb_addr   = lsb_addr_q;
  assign lsb_data   = lsb_data_q;

endmodule

// File: tb/tb_lsb_mem_sequencer.sv
// Directed bench for lsb_mem_sequencer with a byte-wide memory controller model.
module tb_lsb_mem_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, req_signed = 1'b0, flush = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, lsb_wr, lsb_en;
  logic [31:0] resp_rdata, lsb_addr;
  logic [7:0]  lsb_data;
  logic [7:0]  lsb_read_data = 8'd0;
  logic        lsb_valid = 1'b0;

  always #5 clk_in = ~clk_in;

  lsb_mem_sequencer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .lsb_addr      (lsb_addr),
    .lsb_data      (lsb_data),
    .lsb_wr        (lsb_wr),
    .lsb_en        (lsb_en),
    .lsb_read_data (lsb_read_data),
    .lsb_valid     (lsb_valid),
    .flush         (flush)
  );

  // Memory model: 4 KiB aliased on the low 12 address bits.
  logic [7:0]  mem [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = 12'd0;
  logic [7:0]  poke_data = 8'd0;

  always @(posedge clk_in) begin
    lsb_valid <= lsb_en;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (lsb_en) begin
      if (lsb_wr) mem[lsb_addr[11:0]] <= lsb_data;
      else        lsb_read_data <= mem[lsb_addr[11:0]];
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk_in); #1;
    poke_en = 1'b0;
  endtask

  logic        en_log  [16];
  logic        wr_log  [16];
  logic        rv_log  [16];
  logic        rdy_log [16];
  logic [31:0] addr_log[16];
  logic [7:0]  data_log[16];
  logic [31:0] rd_log  [16];

  // Cycle 0 is the accept cycle; cycles 1..15 are logged. flush/rst are asserted
  // during the given cycle only (-1 for none).
  task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int flush_cyc, input int rst_cyc);
    @(posedge clk_in); #1;
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    for (int c = 1; c < 16; c++) begin
      @(posedge clk_in); #1;
      req_valid = 1'b0;
      flush     = (c == flush_cyc);
      rst_in    = (c == rst_cyc);
      #1;
      en_log[c] = lsb_en;   wr_log[c] = lsb_wr;     rv_log[c] = resp_valid;
      rdy_log[c] = req_ready; addr_log[c] = lsb_addr; data_log[c] = lsb_data;
      rd_log[c] = resp_rdata;
    end
    flush = 1'b0; rst_in = 1'b0;
  endtask

  function automatic int count_rv();
    int n = 0;
    for (int c = 1; c < 16; c++) if (rv_log[c]) n++;
    return n;
  endfunction

  function automatic int count_en();
    int n = 0;
    for (int c = 1; c < 16; c++) if (en_log[c]) n++;
    return n;
  endfunction

  initial begin
    // Reset
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_lsb_en", {31'd0, lsb_en}, 32'd0);
    check("rst_lsb_wr", {31'd0, lsb_wr}, 32'd0);
    check("rst_lsb_addr", lsb_addr, 32'd0);
    check("rst_lsb_data", {24'd0, lsb_data}, 32'd0);
    rst_in = 1'b0;

    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    poke(12'h200, 8'h80);
    poke(12'h202, 8'h34); poke(12'h203, 8'h92);
    poke(12'h301, 8'h11); poke(12'h302, 8'h22); poke(12'h303, 8'h55);
    poke(12'hFFE, 8'h11); poke(12'hFFF, 8'h22); poke(12'h000, 8'h33); poke(12'h001, 8'h44);

    // LW at 0x100
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, -1, -1);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("lw_en_c%0d", c), {31'd0, en_log[c]}, 32'd1);
      check($sformatf("lw_addr_c%0d", c), addr_log[c], 32'h100 + c - 1);
    end
    check("lw_en_c5", {31'd0, en_log[5]}, 32'd0);
    check("lw_rv_c5", {31'd0, rv_log[5]}, 32'd0);
    check("lw_rv_c6", {31'd0, rv_log[6]}, 32'd1);
    check("lw_rdata", rd_log[6], 32'h12345678);
    check("lw_rv_count", count_rv(), 1);
    check("lw_rdata_hold", rd_log[10], 32'h12345678);
    check("lw_ready_c7", {31'd0, rdy_log[7]}, 32'd1);

    // LB / LBU at 0x200
    do_req(1'b0, 2'b00, 1'b1, 32'h200, 32'd0, -1, -1);
    check("lb_rv_c3", {31'd0, rv_log[3]}, 32'd1);
    check("lb_rdata", rd_log[3], 32'hFFFFFF80);
    check("lb_en_count", count_en(), 1);
    do_req(1'b0, 2'b00, 1'b0, 32'h200, 32'd0, -1, -1);
    check("lbu_rdata", rd_log[3], 32'h00000080);

    // LH / LHU at 0x202
    do_req(1'b0, 2'b01, 1'b1, 32'h202, 32'd0, -1, -1);
    check("lh_rv_c4", {31'd0, rv_log[4]}, 32'd1);
    check("lh_rdata", rd_log[4], 32'hFFFF9234);
    do_req(1'b0, 2'b01, 1'b0, 32'h202, 32'd0, -1, -1);
    check("lhu_rdata", rd_log[4], 32'h00009234);

    // SH at 0x301, misaligned
    do_req(1'b1, 2'b01, 1'b0, 32'h301, 32'hABCDBEEF, -1, -1);
    check("sh_addr_c1", addr_log[1], 32'h301);
    check("sh_data_c1", {24'd0, data_log[1]}, 32'hEF);
    check("sh_wr_c1", {31'd0, wr_log[1]}, 32'd1);
    check("sh_addr_c2", addr_log[2], 32'h302);
    check("sh_data_c2", {24'd0, data_log[2]}, 32'hBE);
    check("sh_en_c3", {31'd0, en_log[3]}, 32'd0);
    check("sh_rv_c3", {31'd0, rv_log[3]}, 32'd1);
    check("sh_rdata", rd_log[3], 32'd0);
    check("sh_mem301", {24'd0, mem[12'h301]}, 32'hEF);
    check("sh_mem302", {24'd0, mem[12'h302]}, 32'hBE);
    check("sh_mem303", {24'd0, mem[12'h303]}, 32'h55);

    // LW wrapping past 0xFFFFFFFF
    do_req(1'b0, 2'b11, 1'b0, 32'hFFFFFFFE, 32'd0, -1, -1);
    check("wrap_addr_c1", addr_log[1], 32'hFFFFFFFE);
    check("wrap_addr_c2", addr_log[2], 32'hFFFFFFFF);
    check("wrap_addr_c3", addr_log[3], 32'h00000000);
    check("wrap_addr_c4", addr_log[4], 32'h00000001);
    check("wrap_rdata", rd_log[6], 32'h44332211);

    // Reset in cycle 2 of an LW
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, -1, 2);
    check("rstmid_en_c3", {31'd0, en_log[3]}, 32'd0);
    check("rstmid_addr_c3", addr_log[3], 32'd0);
    check("rstmid_rdata_c3", rd_log[3], 32'd0);
    check("rstmid_ready_c3", {31'd0, rdy_log[3]}, 32'd1);
    check("rstmid_rv_count", count_rv(), 0);

    // Flush in cycle 2 of an LW
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 2, -1);
    check("flw_en_c2", {31'd0, en_log[2]}, 32'd1);
    check("flw_en_c3", {31'd0, en_log[3]}, 32'd0);
    check("flw_ready_c3", {31'd0, rdy_log[3]}, 32'd1);
    check("flw_en_count", count_en(), 2);
    check("flw_rv_count", count_rv(), 0);

    // Flush in cycle 2 of an SW is ignored
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, 2, -1);
    check("fsw_en_count", count_en(), 4);
    check("fsw_rv_c5", {31'd0, rv_log[5]}, 32'd1);
    check("fsw_rv_count", count_rv(), 1);
    check("fsw_mem", {mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]}, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
